// File: rtl/spi_tx_fifo.sv
// spi_tx_fifo: host-to-SPI transmit FIFO (circular buffer, 1-cycle read latency).
//
// Ports:
//   clk, rst          - rising-edge clock, synchronous active-high reset
//   din, din_valid    - host write data / strobe (one word per cycle)
//   flush             - synchronous clear of the contents
//   full, almost_full - used = depth_g / used >= almost_full_g (registered)
//   used              - current word count (registered)
//   overflow          - 1-cycle pulse after a write dropped because full
//   rd_req            - read request from the SPI master
//   dout, dout_valid  - read data, presented the cycle after an accepted read
//   empty             - used = 0 (registered)
//   underflow         - 1-cycle pulse after a read requested while empty
module spi_tx_fifo #(
  parameter int data_width_g  = 8,
  parameter int depth_g       = 16,
  parameter int almost_full_g = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [data_width_g-1:0]    din,
  input  logic                       din_valid,
  input  logic                       flush,
  output logic                       full,
  output logic                       almost_full,
  output logic [$clog2(depth_g):0]   used,
  output logic                       overflow,
  input  logic                       rd_req,
  output logic [data_width_g-1:0]    dout,
  output logic                       dout_valid,
  output logic                       empty,
  output logic                       underflow
);

  localparam int AW = $clog2(depth_g);
  localparam logic [AW:0] ONE     = (AW+1)'(1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(depth_g);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(almost_full_g);

  logic [data_width_g-1:0] mem [depth_g];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             used_nxt;
  logic                    wr_ok, rd_ok;

  // Acceptance uses the registered flags, so a full FIFO drops a write even
  // when a read frees a slot in the same cycle.
  assign wr_ok = din_valid & ~full;
  assign rd_ok = rd_req & ~empty;

  always_comb begin
    used_nxt = used;
    unique case ({wr_ok, rd_ok})
      2'b10:   used_nxt = used + ONE;
      2'b01:   used_nxt = used - ONE;
      default: used_nxt = used;
    endcase
  end

  // Storage carries no reset; guarded so flush/reset cycles write nothing.
  always_ff @(posedge clk) begin
    if (!rst && !flush && wr_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      used        <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      dout        <= '0;
      dout_valid  <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else if (flush) begin
      // dout keeps its last value; everything else returns to empty.
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      used        <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      dout_valid  <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr];
      end
      dout_valid  <= rd_ok;
      overflow    <= din_valid & full;
      underflow   <= rd_req & empty;
      used        <= used_nxt;
      empty       <= (used_nxt == '0);
      full        <= (used_nxt == FULL_CNT);
      almost_full <= (used_nxt >= AF_CNT);
    end
  end

endmodule

// File: tb/tb_spi_tx_fifo.sv
module tb_spi_tx_fifo;

  logic       clk = 1'b0;
  logic       rst, din_valid, flush, rd_req;
  logic [7:0] din;
  logic       full, almost_full, overflow, dout_valid, empty, underflow;
  logic [4:0] used;
  logic [7:0] dout;

  int checks = 0;
  int errors = 0;

  spi_tx_fifo #(.data_width_g(8), .depth_g(16), .almost_full_g(12)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .flush(flush),
    .full(full), .almost_full(almost_full), .used(used), .overflow(overflow),
    .rd_req(rd_req), .dout(dout), .dout_valid(dout_valid), .empty(empty),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words plus the output registers.
  logic [7:0] mq[$];
  logic [7:0] m_dout;
  bit         m_dv, m_ov, m_un, chk_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete(); m_dout = 8'h00; m_dv = 0; m_ov = 0; m_un = 0; chk_en = 1;
    end else if (flush) begin
      mq.delete(); m_dv = 0; m_ov = 0; m_un = 0;
    end else begin
      bit was_full, was_empty;
      was_full  = (mq.size() == 16);
      was_empty = (mq.size() == 0);
      m_ov = din_valid && was_full;
      m_un = rd_req && was_empty;
      m_dv = rd_req && !was_empty;
      if (m_dv) m_dout = mq.pop_front();
      if (din_valid && !was_full) mq.push_back(din);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_used",        used,        mq.size());
      chk("m_empty",       empty,       int'(mq.size() == 0));
      chk("m_full",        full,        int'(mq.size() == 16));
      chk("m_almost_full", almost_full, int'(mq.size() >= 12));
      chk("m_dout_valid",  dout_valid,  int'(m_dv));
      chk("m_overflow",    overflow,    int'(m_ov));
      chk("m_underflow",   underflow,   int'(m_un));
      chk("m_dout",        dout,        int'(m_dout));
    end
  end

  task automatic cyc(input logic wv, input logic [7:0] d, input logic rr,
                     input logic fl, input logic r);
    din_valid = wv; din = d; rd_req = rr; flush = fl; rst = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; din_valid = 1'b0; din = 8'h00; rd_req = 1'b0; flush = 1'b0;
    cyc(0, 8'h00, 0, 0, 1);
    cyc(0, 8'h00, 0, 0, 1);
    chk("rst_used", used, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_dout", dout, 0);
    chk("rst_dv", dout_valid, 0);
    cyc(0, 8'h00, 0, 0, 0);

    // Three writes then three back-to-back reads
    cyc(1, 8'h11, 0, 0, 0);
    cyc(1, 8'h22, 0, 0, 0);
    cyc(1, 8'h33, 0, 0, 0);
    chk("t1_used3", used, 3);
    cyc(0, 8'h00, 1, 0, 0); chk("t1_d0", dout, 8'h11); chk("t1_v0", dout_valid, 1);
    cyc(0, 8'h00, 1, 0, 0); chk("t1_d1", dout, 8'h22); chk("t1_v1", dout_valid, 1);
    cyc(0, 8'h00, 1, 0, 0); chk("t1_d2", dout, 8'h33); chk("t1_v2", dout_valid, 1);
    chk("t1_empty", empty, 1);
    cyc(0, 8'h00, 0, 0, 0);
    chk("t1_vlow", dout_valid, 0);
    chk("t1_hold", dout, 8'h33);

    // Fill past full
    for (int i = 0; i < 17; i++) begin
      cyc(1, 8'(i), 0, 0, 0);
      if (i == 10) chk("t2_af_11", almost_full, 0);
      if (i == 11) begin chk("t2_af_12", almost_full, 1); chk("t2_used12", used, 12); end
      if (i == 14) chk("t2_nfull15", full, 0);
      if (i == 15) chk("t2_full16", full, 1);
      if (i == 16) begin chk("t2_ovf", overflow, 1); chk("t2_used16", used, 16); end
    end
    cyc(0, 8'h00, 0, 0, 0);
    chk("t2_ovf_once", overflow, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 8'h00, 1, 0, 0);
      chk("t2_drain", dout, i);
    end
    chk("t2_empty", empty, 1);

    // Read while empty with simultaneous write
    cyc(1, 8'hA5, 1, 0, 0);
    chk("t3_unf", underflow, 1);
    chk("t3_dv", dout_valid, 0);
    chk("t3_used", used, 1);
    cyc(0, 8'h00, 1, 0, 0);
    chk("t3_dout", dout, 8'hA5);
    chk("t3_unf0", underflow, 0);

    // Continuous streaming, 40 words, pointers wrap
    cyc(1, 8'h40, 0, 0, 0);
    cyc(1, 8'h41, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      cyc(1, 8'(8'h42 + i), 1, 0, 0);
      chk("t4_used", used, 2);
      chk("t4_dout", dout, 8'h40 + i);
    end
    cyc(0, 8'h00, 1, 0, 0);
    cyc(0, 8'h00, 1, 0, 0);
    chk("t4_last", dout, 8'h69);
    chk("t4_empty", empty, 1);

    // Flush wins over simultaneous write and read
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'hC0 + i), 0, 0, 0);
    chk("t5_used5", used, 5);
    cyc(1, 8'hEE, 1, 1, 0);
    chk("t5_used", used, 0);
    chk("t5_empty", empty, 1);
    chk("t5_dv", dout_valid, 0);
    chk("t5_ovf", overflow, 0);
    chk("t5_unf", underflow, 0);
    cyc(0, 8'h00, 1, 0, 0);
    chk("t5_unf_after", underflow, 1);

    // Reset mid-burst
    for (int i = 0; i < 8; i++) cyc(1, 8'(8'h80 + i), 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0);
    cyc(0, 8'h00, 1, 0, 0);
    chk("t6_pre", dout, 8'h81);
    cyc(1, 8'h99, 1, 1, 1);
    chk("t6_used", used, 0);
    chk("t6_empty", empty, 1);
    chk("t6_full", full, 0);
    chk("t6_af", almost_full, 0);
    chk("t6_dout", dout, 0);
    chk("t6_dv", dout_valid, 0);
    chk("t6_ovf", overflow, 0);
    chk("t6_unf", underflow, 0);
    cyc(1, 8'h5A, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0);
    chk("t6_rd", dout, 8'h5A);
    chk("t6_rdv", dout_valid, 1);
    cyc(0, 8'h00, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
